// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and IF/ID register with redirect, halt and misalignment fault; FETCH_PERF_EN adds perf counters
module fetch_stage #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          IMEM_DEPTH   = 128,
    parameter bit          HALT_ON_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0] perf_fetch_count,
    output logic [15:0] perf_flush_count,
`endif
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        halted,
    output logic        fault
);
    typedef enum logic [1:0] {RUN, HALT, FAULT} state_t;
    state_t      state;
    logic [31:0] pc;
    logic        accept;
    logic        out_of_range;
    logic        end_word;
    assign imem_addr    = pc >> 2;
    assign accept       = !id_valid || id_ready;
    assign out_of_range = {2'b00, pc[31:2]} >= 32'(IMEM_DEPTH);
    assign end_word     = HALT_ON_ZERO && (imem_rdata == 32'h0);
    assign halted       = state == HALT;
    assign fault        = state == FAULT;
    // PC, fetch state and IF/ID register; redirect outranks range and zero checks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            state    <= RUN;
            id_valid <= 1'b0;
            id_instr <= 32'h0;
            id_pc    <= 32'h0;
        end else if (state == FAULT) begin
            id_valid <= 1'b0;
        end else if (redirect_valid) begin
            id_valid <= 1'b0;
            if (redirect_pc[1:0] == 2'b00) begin
                pc    <= redirect_pc;
                state <= RUN;
            end else begin
                state <= FAULT;
            end
        end else if (state == HALT) begin
            if (id_ready) id_valid <= 1'b0;
        end else if (accept) begin
            if (out_of_range || end_word) begin
                state    <= HALT;
                id_valid <= 1'b0;
            end else begin
                id_instr <= imem_rdata;
                id_pc    <= pc;
                id_valid <= 1'b1;
                pc       <= pc + 32'd4;
            end
        end
    end
`ifdef FETCH_PERF_EN
    logic do_fetch;
    logic do_flush;
    assign do_fetch = (state == RUN) && !redirect_valid && accept && !out_of_range && !end_word;
    assign do_flush = (state != FAULT) && redirect_valid && id_valid;
    // Free-running wrap-around counters of issued fetches and flushed instructions
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_count <= 32'h0;
            perf_flush_count <= 16'h0;
        end else begin
            perf_fetch_count <= perf_fetch_count + 32'(do_fetch);
            perf_flush_count <= perf_flush_count + 16'(do_flush);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus against a behavioural fetch model
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr, imem_rdata, redirect_pc, id_instr, id_pc;
    logic        redirect_valid, id_ready, id_valid, halted, fault;
    logic [31:0] r_addr, r_data, r_instr, r_pc;
    logic        r_valid, r_halted, r_fault;
    logic [31:0] rom [128];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_v;
    int          m_st;

    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'd128) ? rom[imem_addr[6:0]] : 32'h0;
    assign r_data     = (r_addr < 32'd128) ? 32'hDEAD_BEEF : 32'h0;

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .halted(halted), .fault(fault)
    );

    fetch_stage #(.RESET_PC(32'd508)) u_rng (
        .clk(clk), .rst_n(rst_n), .imem_addr(r_addr), .imem_rdata(r_data),
        .redirect_valid(1'b0), .redirect_pc(32'h0), .id_ready(1'b1),
        .id_valid(r_valid), .id_instr(r_instr), .id_pc(r_pc), .halted(r_halted), .fault(r_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_st = 0; m_v = 1'b0; m_instr = 32'h0; m_ipc = 32'h0;
    endtask

    // one clock edge of the fetch stage; st: 0 run, 1 halt, 2 fault
    task automatic model_edge();
        logic [31:0] w;
        w = m_pc >> 2;
        if (m_st == 2) m_v = 1'b0;
        else if (redirect_valid) begin
            m_v = 1'b0;
            if (redirect_pc % 4 == 0) begin m_pc = redirect_pc; m_st = 0; end
            else m_st = 2;
        end else if (m_st == 1) begin
            if (id_ready) m_v = 1'b0;
        end else if (!m_v || id_ready) begin
            if (w >= 128 || rom[w[6:0]] == 32'h0) begin m_st = 1; m_v = 1'b0; end
            else begin m_instr = rom[w[6:0]]; m_ipc = m_pc; m_v = 1'b1; m_pc = m_pc + 4; end
        end
    endtask

    task automatic compare(input string tag);
        chk({tag, ".valid"}, 32'(id_valid), 32'(m_v));
        chk({tag, ".instr"}, id_instr, m_instr);
        chk({tag, ".pc"}, id_pc, m_ipc);
        chk({tag, ".addr"}, imem_addr, m_pc >> 2);
        chk({tag, ".halted"}, 32'(halted), 32'(m_st == 1));
        chk({tag, ".fault"}, 32'(fault), 32'(m_st == 2));
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        compare(tag);
    endtask

    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        compare(tag);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'(i + 1);
        redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
        model_reset();
        #12;
        compare("reset");
        chk("rng_reset_pc", r_addr, 32'd127);
        rst_n = 1'b1;
        step("stream0");
        chk("stream0_pc", id_pc, 32'h0);
        chk("stream0_instr", id_instr, 32'd1);
        chk("rng_valid", 32'(r_valid), 32'd1);
        chk("rng_pc", r_pc, 32'd508);
        chk("rng_instr", r_instr, 32'hDEAD_BEEF);
        step("stream1");
        chk("stream1_instr", id_instr, 32'd2);
        chk("rng_halted", 32'(r_halted), 32'd1);
        chk("rng_drop", 32'(r_valid), 32'd0);
        id_ready = 1'b0;
        repeat (3) step("stall");
        chk("stall_instr", id_instr, 32'd2);
        chk("stall_pc", id_pc, 32'd4);
        chk("stall_addr", imem_addr, 32'd2);
        id_ready = 1'b1;
        step("resume");
        chk("resume_instr", id_instr, 32'd3);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step("redir");
        chk("redir_bubble", 32'(id_valid), 32'd0);
        redirect_valid = 1'b0;
        step("redir_tgt");
        chk("redir_tgt_pc", id_pc, 32'h40);
        chk("redir_tgt_instr", id_instr, 32'd17);
        rom[5] = 32'h0;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step("eop_redir");
        redirect_valid = 1'b0;
        repeat (8) step("eop");
        chk("eop_halted", 32'(halted), 32'd1);
        chk("eop_valid", 32'(id_valid), 32'd0);
        chk("eop_last_pc", id_pc, 32'd16);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        step("restart_redir");
        redirect_valid = 1'b0;
        step("restart");
        chk("restart_pc", id_pc, 32'h0);
        chk("restart_halted", 32'(halted), 32'd0);
        redirect_valid = 1'b1; redirect_pc = 32'h22;
        step("misalign");
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_valid", 32'(id_valid), 32'd0);
        redirect_pc = 32'h40;
        step("fault_ignore");
        chk("fault_sticky", 32'(fault), 32'd1);
        chk("fault_pc_hold", imem_addr, 32'd1);
        redirect_valid = 1'b0;
        async_reset("async_rst");
        chk("async_rst_fault", 32'(fault), 32'd0);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 128; i++) rom[i] = ($urandom_range(0, 19) == 0) ? 32'h0 : ($urandom | 32'h1);
            async_reset("rand_rst");
            for (int c = 0; c < 250; c++) begin
                id_ready = $urandom_range(0, 3) != 0;
                redirect_valid = $urandom_range(0, 9) == 0;
                redirect_pc = 32'($urandom_range(0, 139)) * 32'd4;
                if ($urandom_range(0, 29) == 0) redirect_pc = redirect_pc + 32'($urandom_range(1, 3));
                step("rand");
            end
            redirect_valid = 1'b0;
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
